// File: rtl/cdc_hs_tx_pkg.sv
// Shared state encoding and synchronizer depth for the handshake CDC source end.
// Pure declarations: no latency, no flow control.
package cdc_pkg;
    typedef enum logic [1:0] {IDLE, REQ, ACK} hs_tx_state_e;
    localparam int SYNC_LAT = 2;
endpackage

// File: rtl/cdc_hs_tx_if.sv
// Handshake bundle between the source-side user, cdc_hs_tx and the destination ack path.
// Signal names are seen from the transmitter: slave = cdc_hs_tx, master = everything around it.
interface cdc_hs_tx_if #(parameter int DATA_W = 8);
    logic              valid_i;
    logic [DATA_W-1:0] data_i;
    logic              ready_o;
    logic              req_o;
    logic [DATA_W-1:0] data_o;
    logic              ack_i;
    logic              done_o;
    logic              err_o;

    modport master (output valid_i, data_i, ack_i,
                    input  ready_o, req_o, data_o, done_o, err_o);
    modport slave  (input  valid_i, data_i, ack_i,
                    output ready_o, req_o, data_o, done_o, err_o);
endinterface

// File: rtl/cdc_hs_tx_sync.sv
// Multi-flop synchronizer for a single asynchronous level; SYNC_LAT edges of latency.
// Synchronous active-low clear, no flow control.
module sync_2dff
    import cdc_pkg::*;
(
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);
    logic [SYNC_LAT-1:0] sr;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sr <= '0;
        end else begin
            sr <= {sr[SYNC_LAT-2:0], d_i};
        end
    end

    assign q_o = sr[SYNC_LAT-1];
endmodule

// File: rtl/cdc_hs_tx.sv
// Source end of a 4-phase req/ack CDC handshake: accept one word, hold it, req until ack, done on ack release.
// Accept-to-req 1 cycle; ready only in IDLE with synced ack low. CDC_HS_TIMEOUT_EN adds a phase timeout + sticky err.
module cdc_hs_tx
    import cdc_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 64
)(
    input  logic        clk_i,
    input  logic        rstn_i,
    cdc_hs_tx_if.slave  bus
);
    hs_tx_state_e      state, state_n;
    logic              ack_s;
    logic              ready;
    logic              req_q, req_n;
    logic              done_q, done_n;
    logic              err_q, err_n;
    logic              abort_q, abort_n;
    logic [DATA_W-1:0] data_q, data_n;
    logic              tmo_hit;

    if (TIMEOUT_CYC < 2) begin : g_tmo_range
        $error("cdc_hs_tx: TIMEOUT_CYC must be at least 2");
    end

    sync_2dff u_ack_sync (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (bus.ack_i),
        .q_o    (ack_s)
    );

`ifdef CDC_HS_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // Counts cycles spent in the current handshake phase; any phase change restarts it.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt <= '0;
        end else if (state_n != state) begin
            cnt <= '0;
        end else if (state != IDLE) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tmo_hit = (cnt == CNT_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    assign ready = (state == IDLE) && !ack_s;

    always_comb begin
        state_n = state;
        req_n   = req_q;
        data_n  = data_q;
        done_n  = 1'b0;
        err_n   = err_q;
        abort_n = abort_q;
        case (state)
            IDLE: begin
                if (bus.valid_i && ready) begin
                    data_n  = bus.data_i;
                    req_n   = 1'b1;
                    abort_n = 1'b0;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    req_n   = 1'b0;
                    state_n = ACK;
                end else if (tmo_hit) begin
                    req_n   = 1'b0;
                    err_n   = 1'b1;
                    abort_n = 1'b1;
                    state_n = ACK;
                end
            end
            ACK: begin
                // A transfer whose request phase timed out still closes the 4-phase loop but never reports done.
                if (!ack_s) begin
                    done_n  = !abort_q;
                    state_n = IDLE;
                end else if (tmo_hit) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                req_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state   <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state   <= state_n;
            req_q   <= req_n;
            data_q  <= data_n;
            done_q  <= done_n;
            err_q   <= err_n;
            abort_q <= abort_n;
        end
    end

    assign bus.ready_o = ready;
    assign bus.req_o   = req_q;
    assign bus.data_o  = data_q;
    assign bus.done_o  = done_q;
    assign bus.err_o   = err_q;
endmodule
